// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: FIFO-fed command sequencer that drives a downstream jk_ff and checks its q against a shadow model.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  input  logic [3:0]       cmd_len,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic             shadow_q,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t         state;
  logic [5:0]     mem [DEPTH];
  logic [AW-1:0]  rptr, wptr;
  logic [AW:0]    count;
  logic [1:0]     cur_cmd;
  logic [3:0]     remaining;
  logic           push, pop, diff;
  logic [5:0]     head;
  assign cmd_ready = count < (AW+1)'(DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rptr];
  // pop when idle, or on the last drive cycle so the next command follows with no gap
  assign pop       = (count != '0) && (state == IDLE || remaining == 4'd1);
  assign busy      = (state == DRIVE) || (count != '0);
  assign diff      = q_in != shadow_q;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {cmd, cmd_len};
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      cur_cmd   <= 2'b00;
      remaining <= 4'd0;
      j         <= 1'b0;
      k         <= 1'b0;
      shadow_q  <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      {j, k} <= (state == DRIVE) ? cur_cmd : 2'b00;
      if (pop) begin
        cur_cmd   <= head[5:4];
        remaining <= (head[3:0] == 4'd0) ? 4'd1 : head[3:0];
        state     <= DRIVE;
      end else if (state == DRIVE) begin
        remaining <= remaining - 4'd1;
        state     <= (remaining == 4'd1) ? IDLE : DRIVE;
      end
      shadow_q  <= ({j, k} == 2'b01) ? 1'b0 : ({j, k} == 2'b10) ? 1'b1 :
                   ({j, k} == 2'b11) ? ~shadow_q : shadow_q;
      mismatch  <= diff;
      if (diff && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb_jk_cmd_seq: directed table, corner sequences and randomized traffic checked against a queue-based model.
module tb_jk_cmd_seq;
  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic [1:0] cmd = 0;
  logic [3:0] cmd_len = 0;
  logic q_in, cmd_ready, j, k, busy, shadow_q, mismatch;
  logic [ERR_W-1:0] err_count;
  logic q_ff = 0, frc = 0, frc_val = 0;
  int pass_n = 0, total_n = 0;
  bit chk_en = 0;

  jk_cmd_seq #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .j(j), .k(k), .q_in(q_in), .busy(busy),
    .shadow_q(shadow_q), .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // downstream flop the sequencer talks to; q_in can be overridden to inject faults
  assign q_in = frc ? frc_val : q_ff;
  always @(posedge clk)
    q_ff <= rst ? 1'b0 : ({j, k} == 2'b01) ? 1'b0 : ({j, k} == 2'b10) ? 1'b1 :
            ({j, k} == 2'b11) ? ~q_ff : q_ff;

  // reference: pending commands plus a per-cycle plan of future j/k values
  logic [5:0] mq[$];
  logic [1:0] plan[$];
  logic [1:0] m_jk = 0, jo, pc;
  logic m_sh = 0, m_mis = 0, push_ok;
  logic [ERR_W-1:0] m_err = 0;
  logic [5:0] e;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); plan.delete();
      m_jk = 0; m_sh = 0; m_mis = 0; m_err = 0;
    end else begin
      jo = m_jk;
      m_mis = (q_in != m_sh);
      if (m_mis && m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
      m_sh = (jo == 2'b01) ? 1'b0 : (jo == 2'b10) ? 1'b1 : (jo == 2'b11) ? ~m_sh : m_sh;
      push_ok = cmd_valid && (mq.size() < DEPTH);
      if (plan.size() > 0) m_jk = plan.pop_front(); else m_jk = 2'b00;
      if (plan.size() == 0 && mq.size() > 0) begin
        e = mq.pop_front();
        pc = e[5:4];
        for (int n = 0; n < ((e[3:0] == 0) ? 1 : int'(e[3:0])); n++) plan.push_back(pc);
      end
      if (push_ok) mq.push_back({cmd, cmd_len});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else pass_n++;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("model_jk", {30'd0, j, k}, {30'd0, m_jk});
    chk("model_shadow", {31'd0, shadow_q}, {31'd0, m_sh});
    chk("model_mismatch", {31'd0, mismatch}, {31'd0, m_mis});
    chk("model_err", 32'(err_count), 32'(m_err));
    chk("model_ready", {31'd0, cmd_ready}, {31'd0, mq.size() < DEPTH});
    chk("model_busy", {31'd0, busy}, {31'd0, (plan.size() > 0) || (mq.size() > 0)});
  end

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic push(input logic [1:0] c, input logic [3:0] l);
    logic acc;
    int n;
    cmd_valid = 1; cmd = c; cmd_len = l; n = 0;
    do begin
      @(posedge clk);
      acc = cmd_ready;
      n++;
    end while (!acc && n < 200);
    chk("push_accept", {31'd0, acc}, 32'd1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  typedef struct {logic [1:0] c; logic [3:0] l; int n; logic sh;} vec_t;
  vec_t vt[7];
  logic [1:0] seq_jk[10];
  logic seq_sh[5];

  initial begin
    vt[0] = '{2'b10, 4'd3, 3, 1'b1};
    vt[1] = '{2'b01, 4'd0, 1, 1'b0};
    vt[2] = '{2'b11, 4'd4, 4, 1'b0};
    vt[3] = '{2'b11, 4'd3, 3, 1'b1};
    vt[4] = '{2'b10, 4'd15, 15, 1'b1};
    vt[5] = '{2'b11, 4'd0, 1, 1'b1};
    vt[6] = '{2'b00, 4'd2, 2, 1'b0};
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", 32'(err_count), 32'd0);
    // single command into an idle block: drive starts 2 cycles after the push edge
    for (int v = 0; v < 7; v++) begin
      do_reset();
      push(vt[v].c, vt[v].l);
      for (int c = 1; c <= vt[v].n + 2; c++) begin
        @(negedge clk);
        chk("tbl_jk", {30'd0, j, k}, {30'd0, (c >= 2 && c <= vt[v].n + 1) ? vt[v].c : 2'b00});
        chk("tbl_mismatch", {31'd0, mismatch}, 32'd0);
      end
      chk("tbl_shadow", {31'd0, shadow_q}, {31'd0, vt[v].sh});
    end
    // back-to-back toggle/4 then clear/0
    do_reset();
    push(2'b11, 4'd4);
    push(2'b01, 4'd0);
    seq_sh = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      chk("b2b_jk", {30'd0, j, k}, {30'd0, (c <= 5) ? 2'b11 : (c == 6) ? 2'b01 : 2'b00});
      if (c >= 3) chk("b2b_shadow", {31'd0, shadow_q}, {31'd0, seq_sh[c-3]});
    end
    // fill the FIFO behind a long command
    do_reset();
    push(2'b10, 4'd15);
    @(negedge clk);
    push(2'b11, 4'd1);
    push(2'b01, 4'd2);
    push(2'b10, 4'd3);
    push(2'b11, 4'd2);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    push(2'b01, 4'd1);
    seq_jk = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      chk("order_jk", {30'd0, j, k}, {30'd0, seq_jk[c]});
    end
    // forced disagreement for 3 cycles
    do_reset();
    frc_val = 1; frc = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("force_mismatch", {31'd0, mismatch}, 32'd1);
    end
    frc = 0;
    @(negedge clk);
    chk("force_release", {31'd0, mismatch}, 32'd0);
    chk("force_err", 32'(err_count), 32'd3);
    // saturation
    do_reset();
    frc = 1;
    repeat (300) @(negedge clk);
    chk("sat_err", 32'(err_count), 32'd255);
    chk("sat_mismatch", {31'd0, mismatch}, 32'd1);
    frc = 0;
    // reset in the middle of a long toggle with two entries queued
    do_reset();
    push(2'b11, 4'd8);
    push(2'b10, 4'd2);
    push(2'b01, 4'd3);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_jk", {30'd0, j, k}, 32'd0);
    chk("rst_shadow", {31'd0, shadow_q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rst_quiet", {30'd0, j, k}, 32'd0);
    end
    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd = 2'($urandom_range(0, 3));
      cmd_len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      frc = ($urandom_range(0, 9) == 0);
      frc_val = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    cmd_valid = 0; frc = 0; rst = 0;
    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
